// File: rtl/relu_maxpool22_if.sv
// Stream bundle between the conv unit, the ReLU/max-pool stage and its consumer.
// The slave side is the pooling stage: it takes conv results and emits pooled activations.
interface relu_maxpool22_if #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8
);
  logic                        in_valid;
  logic signed [IN_WIDTH-1:0]  in_data;
  logic                        out_valid;
  logic signed [OUT_WIDTH-1:0] out_data;
  logic                        out_last;

  modport master (
    output in_valid,
    output in_data,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output out_valid,
    output out_data,
    output out_last
  );
endinterface

// File: rtl/relu_maxpool22.sv
// ReLU + 2x2 stride-2 max pooling + shift/saturate requantization on a raster stream.
// A half-row buffer keeps the even-row pair maxima until the matching odd row arrives.
module relu_maxpool22 #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned MAP_W     = 10,
  parameter int unsigned MAP_H     = 10,
  parameter int unsigned SHIFT     = 8
) (
  input logic                clk,
  input logic                rst,
  relu_maxpool22_if.slave    bus
);

  localparam int unsigned HalfW = MAP_W / 2;
  localparam int unsigned CW    = $clog2(MAP_W);
  localparam int unsigned RW    = $clog2(MAP_H);
  localparam int unsigned IW    = (HalfW > 1) ? $clog2(HalfW) : 1;
  localparam int unsigned VW    = IN_WIDTH - 1;
  localparam logic [VW-1:0] SatMax = VW'((1 << (OUT_WIDTH - 1)) - 1);

  if ((MAP_W % 2 != 0) || (MAP_W < 2)) begin : g_bad_map_w
    $error("relu_maxpool22: MAP_W must be even and >= 2");
  end
  if ((MAP_H % 2 != 0) || (MAP_H < 2)) begin : g_bad_map_h
    $error("relu_maxpool22: MAP_H must be even and >= 2");
  end
  if (SHIFT >= IN_WIDTH) begin : g_bad_shift
    $error("relu_maxpool22: SHIFT must be below IN_WIDTH");
  end
  if (OUT_WIDTH >= IN_WIDTH) begin : g_bad_out_width
    $error("relu_maxpool22: OUT_WIDTH must be below IN_WIDTH");
  end

  logic [CW-1:0]        r_col;
  logic [RW-1:0]        r_row;
  logic [VW-1:0]        r_hold;
  logic [VW-1:0]        r_lbuf [HalfW];
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;
  logic                 r_out_last;

  logic [VW-1:0]        w_relu;
  logic [VW-1:0]        w_pair;
  logic [VW-1:0]        w_max;
  logic [VW-1:0]        w_shift;
  logic [OUT_WIDTH-1:0] w_quant;
  logic [IW-1:0]        w_idx;
  logic                 w_col_last;
  logic                 w_row_last;
  logic                 w_emit;
  logic                 w_store;

  // Sign bit dropped: after ReLU every value is non-negative.
  always_comb begin
    w_relu     = bus.in_data[IN_WIDTH-1] ? '0 : bus.in_data[VW-1:0];
    w_pair     = (w_relu > r_hold) ? w_relu : r_hold;
    w_idx      = IW'(r_col >> 1);
    w_max      = (r_lbuf[w_idx] > w_pair) ? r_lbuf[w_idx] : w_pair;
    w_shift    = w_max >> SHIFT;
    w_quant    = (w_shift > SatMax) ? OUT_WIDTH'(SatMax) : OUT_WIDTH'(w_shift);
    w_col_last = (r_col == CW'(MAP_W - 1));
    w_row_last = (r_row == RW'(MAP_H - 1));
    w_emit     = bus.in_valid & r_col[0] & r_row[0];
    w_store    = bus.in_valid & r_col[0] & ~r_row[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= w_emit;
      r_out_last  <= w_emit & w_col_last & w_row_last;
      if (w_emit) begin
        r_out_data <= w_quant;
      end
      if (bus.in_valid) begin
        if (!r_col[0]) begin
          r_hold <= w_relu;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
    end
  end

  // Not reset: each entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (w_store) begin
      r_lbuf[w_idx] <= w_pair;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_relu_maxpool22.sv
// Directed bench: a 4x4 SHIFT=0 instance for pooling/timing/reset and a
// 2x2 SHIFT=8 instance for requantization and saturation.
module tb_relu_maxpool22;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  relu_maxpool22_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus0 ();
  relu_maxpool22_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) bus1 ();

  relu_maxpool22 #(
    .IN_WIDTH(32), .OUT_WIDTH(8), .MAP_W(4), .MAP_H(4), .SHIFT(0)
  ) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  relu_maxpool22 #(
    .IN_WIDTH(32), .OUT_WIDTH(8), .MAP_W(2), .MAP_H(2), .SHIFT(8)
  ) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  // Expected pooled value at each raster beat of a 4x4 frame (0 where no output).
  int exp_asc  [16] = '{0, 0, 0, 0, 0, 6,  0, 8,  0, 0, 0, 0, 0, 14, 0, 16};
  int exp_desc [16] = '{0, 0, 0, 0, 0, 16, 0, 14, 0, 0, 0, 0, 0, 8,  0, 6};

  // 2x2 blocks for the SHIFT=8 instance, raster order, with expected outputs.
  int blk_in  [16] = '{1, 2, 3, 'h10000,
                       'h3FFF, 0, 5, 7,
                       -100, 'h7FFF, -1, 'h10,
                       'h80, 'h17F, -32'sh7FFFFFFF, 'h100};
  int blk_exp [4]  = '{127, 63, 127, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat0(input string tag, input int d, input bit ev, input int ed, input bit el);
    bus0.in_valid = 1'b1;
    bus0.in_data  = d;
    @(posedge clk);
    #1;
    bus0.in_valid = 1'b0;
    chk({tag, " valid"}, {31'b0, bus0.out_valid}, {31'b0, ev});
    chk({tag, " last"}, {31'b0, bus0.out_last}, {31'b0, el});
    if (ev) chk({tag, " data"}, 32'(bus0.out_data), ed);
  endtask

  task automatic idle0(input string tag, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      chk({tag, " gap valid"}, {31'b0, bus0.out_valid}, 32'd0);
    end
  endtask

  // desc=0 sends 1..16, desc=1 sends 16..1; gap>0 inserts 0..gap idle cycles per beat.
  task automatic frame0(input string tag, input bit desc, input int gap);
    for (int i = 0; i < 16; i++) begin
      int d;
      int ed;
      d  = desc ? 16 - i : i + 1;
      ed = desc ? exp_desc[i] : exp_asc[i];
      beat0(tag, d, ed != 0, ed, i == 15);
      if (gap > 0) idle0(tag, $urandom_range(gap));
    end
  endtask

  initial begin
    bus0.in_valid = 1'b0;
    bus0.in_data  = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;

    #1;
    chk("reset valid", {31'b0, bus0.out_valid}, 32'd0);
    chk("reset data", 32'(bus0.out_data), 32'd0);
    chk("reset last", {31'b0, bus0.out_last}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    frame0("asc", 1'b0, 0);

    for (int i = 0; i < 16; i++) begin
      beat0("neg", -5, exp_asc[i] != 0, 0, i == 15);
      chk("neg no x", {31'b0, $isunknown(bus0.out_data)}, 32'd0);
    end

    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < 4; j++) begin
        bus1.in_valid = 1'b1;
        bus1.in_data  = blk_in[b*4+j];
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
        chk("quant valid", {31'b0, bus1.out_valid}, {31'b0, j == 3});
        chk("quant last", {31'b0, bus1.out_last}, {31'b0, j == 3});
        if (j == 3) chk("quant data", 32'(bus1.out_data), blk_exp[b]);
      end
    end

    frame0("gaps", 1'b0, 5);

    frame0("b2b first", 1'b0, 0);
    frame0("b2b second", 1'b1, 0);

    for (int i = 0; i < 6; i++) begin
      beat0("pre rst", i + 1, exp_asc[i] != 0, exp_asc[i], 1'b0);
    end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst valid", {31'b0, bus0.out_valid}, 32'd0);
    chk("async rst data", 32'(bus0.out_data), 32'd0);
    chk("async rst last", {31'b0, bus0.out_last}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    frame0("post rst", 1'b0, 0);
    idle0("tail", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
